// File: rtl/otter_pkg.sv
// Shared definitions for the OTTER control unit: state encoding and
// RV32I major opcodes used by the decoder and the control FSM.
package otter_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        INTR  = 3'd4
    } cu_state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    // SYSTEM funct3 values that matter to the control unit
    localparam logic [2:0] F3_MRET   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;

endpackage

// File: rtl/cu_fsm.sv
// OTTER multi-cycle control unit: INIT/FETCH/EXEC/WB/INTR sequencer that
// produces the datapath write/read enables from the current state and,
// in EXEC, from the instruction opcode/funct3.
module cu_fsm
    import otter_pkg::*;
#(
    parameter bit INTR_EN = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       intr,
    output logic       PCWrite,
    output logic       regWrite,
    output logic       memWE2,
    output logic       memRDEN1,
    output logic       memRDEN2,
    output logic       reset,
    output logic       csr_WE,
    output logic       int_taken,
    output logic       mret_exec
);

    cu_state_t r_state;
    cu_state_t w_next;
    logic      w_intr_req;

    // Interrupt requests are dropped entirely when the trap path is not built
    assign w_intr_req = intr & INTR_EN;

    // State register; reset wins over every transition
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next    = FETCH;
        PCWrite   = 1'b0;
        regWrite  = 1'b0;
        memWE2    = 1'b0;
        memRDEN1  = 1'b0;
        memRDEN2  = 1'b0;
        reset     = 1'b0;
        csr_WE    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;

        case (r_state)
            INIT: begin
                reset  = 1'b1;
                w_next = FETCH;
            end

            FETCH: begin
                // Interrupts are only taken at instruction boundaries
                memRDEN1 = 1'b1;
                w_next   = EXEC;
            end

            EXEC: begin
                w_next = w_intr_req ? INTR : FETCH;
                case (opcode)
                    OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                        PCWrite  = 1'b1;
                        regWrite = 1'b1;
                    end
                    OP_BRANCH: begin
                        PCWrite = 1'b1;
                    end
                    OP_STORE: begin
                        PCWrite = 1'b1;
                        memWE2  = 1'b1;
                    end
                    OP_LOAD: begin
                        // PC advances in WB so the load completes first
                        memRDEN2 = 1'b1;
                        w_next   = WB;
                    end
                    OP_SYS: begin
                        PCWrite = 1'b1;
                        case (funct3)
                            F3_MRET: begin
                                mret_exec = 1'b1;
                            end
                            F3_CSRRW, F3_CSRRS, F3_CSRRC: begin
                                regWrite = 1'b1;
                                csr_WE   = 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                    default: begin
                        PCWrite = 1'b1;
                    end
                endcase
            end

            WB: begin
                regWrite = 1'b1;
                PCWrite  = 1'b1;
                w_next   = w_intr_req ? INTR : FETCH;
            end

            INTR: begin
                // Always return to FETCH so at least one instruction runs
                int_taken = 1'b1;
                PCWrite   = 1'b1;
                w_next    = FETCH;
            end

            default: begin
                w_next = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_cu_fsm.sv
// Self-checking bench for cu_fsm: directed scenarios followed by random
// instruction/interrupt/reset traffic against a behavioural model. Two
// instances run side by side, one with the interrupt path and one without.
module tb_cu_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       intr;

    logic pcw1, rw1, we1, rd1_1, rd2_1, rst1, csr1, int1, mret1;
    logic pcw0, rw0, we0, rd1_0, rd2_0, rst0, csr0, int0, mret0;

    int n_cmp = 0;
    int n_bad = 0;

    // Output vector layout: {PCWrite,regWrite,memWE2,memRDEN1,memRDEN2,reset,csr_WE,int_taken,mret_exec}
    localparam logic [8:0] O_PC   = 9'b100000000;
    localparam logic [8:0] O_RW   = 9'b010000000;
    localparam logic [8:0] O_WE   = 9'b001000000;
    localparam logic [8:0] O_RD1  = 9'b000100000;
    localparam logic [8:0] O_RD2  = 9'b000010000;
    localparam logic [8:0] O_RST  = 9'b000001000;
    localparam logic [8:0] O_CSR  = 9'b000000100;
    localparam logic [8:0] O_INT  = 9'b000000010;
    localparam logic [8:0] O_MRET = 9'b000000001;

    // Model phases: which step of the instruction cycle the control unit is in
    localparam int PH_UNK = -1, PH_INIT = 0, PH_FETCH = 1, PH_EXEC = 2, PH_WB = 3, PH_TRAP = 4;

    int ph1 = PH_UNK;
    int ph0 = PH_UNK;
    bit en0_trapped = 1'b0;

    always #5 CLK = ~CLK;

    cu_fsm #(.INTR_EN(1'b1)) dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .intr(intr),
        .PCWrite(pcw1), .regWrite(rw1), .memWE2(we1), .memRDEN1(rd1_1),
        .memRDEN2(rd2_1), .reset(rst1), .csr_WE(csr1), .int_taken(int1),
        .mret_exec(mret1)
    );

    cu_fsm #(.INTR_EN(1'b0)) dut_noint (
        .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .intr(intr),
        .PCWrite(pcw0), .regWrite(rw0), .memWE2(we0), .memRDEN1(rd1_0),
        .memRDEN2(rd2_0), .reset(rst0), .csr_WE(csr0), .int_taken(int0),
        .mret_exec(mret0)
    );

    wire [8:0] v1 = {pcw1, rw1, we1, rd1_1, rd2_1, rst1, csr1, int1, mret1};
    wire [8:0] v0 = {pcw0, rw0, we0, rd1_0, rd2_0, rst0, csr0, int0, mret0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_load(input logic [6:0] op);
        return op == 7'b0000011;
    endfunction

    // Expected enables for a phase, described by what the instruction needs
    function automatic logic [8:0] expect_out(input int ph, input logic [6:0] op, input logic [2:0] f3);
        bit writes_rd;
        writes_rd = (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0110111) ||
                    (op == 7'b0010111) || (op == 7'b1101111) || (op == 7'b1100111);
        if (ph == PH_INIT)  return O_RST;
        if (ph == PH_FETCH) return O_RD1;
        if (ph == PH_WB)    return O_PC | O_RW;
        if (ph == PH_TRAP)  return O_PC | O_INT;
        if (is_load(op))          return O_RD2;
        if (op == 7'b0100011)     return O_PC | O_WE;
        if (writes_rd)            return O_PC | O_RW;
        if (op == 7'b1110011) begin
            if (f3 == 3'd0)                 return O_PC | O_MRET;
            if (f3 >= 3'd1 && f3 <= 3'd3)   return O_PC | O_RW | O_CSR;
        end
        return O_PC;
    endfunction

    function automatic int next_phase(input int ph, input bit rst, input bit irq, input bit en,
                                      input logic [6:0] op);
        if (rst) return PH_INIT;
        if (ph == PH_UNK) return PH_UNK;
        if (ph == PH_INIT || ph == PH_TRAP) return PH_FETCH;
        if (ph == PH_FETCH) return PH_EXEC;
        if (ph == PH_EXEC && is_load(op)) return PH_WB;
        return (irq && en) ? PH_TRAP : PH_FETCH;
    endfunction

    function automatic int ones(input logic [8:0] v);
        return int'(v[6]) + int'(v[5]) + int'(v[4]);
    endfunction

    // Apply inputs just after an edge and compare both instances at the falling edge
    task automatic drive(input bit r, input logic [6:0] op, input logic [2:0] f3, input bit i);
        RST = r; opcode = op; funct3 = f3; intr = i;
        @(negedge CLK);
        chk("model_en1", v1, expect_out(ph1, op, f3));
        chk("model_en0", v0, expect_out(ph0, op, f3));
        chk("mem_excl", (ones(v1) <= 1), 1);
        chk("no_x", {31'd0, $isunknown({v1, v0})}, 0);
        if (int0) en0_trapped = 1'b1;
    endtask

    task automatic tick();
        int n1, n0;
        n1 = next_phase(ph1, RST, intr, 1'b1, opcode);
        n0 = next_phase(ph0, RST, intr, 1'b0, opcode);
        @(posedge CLK);
        #1;
        ph1 = n1;
        ph0 = n0;
    endtask

    initial begin
        logic [6:0] ops [11];
        logic [6:0] op;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
                7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011, 7'b1111111};

        RST = 1'b1; opcode = '0; funct3 = '0; intr = 1'b0;
        tick();
        tick();

        // Reset release: INIT then FETCH
        drive(0, 7'b0110011, 3'd0, 0); chk("init_reset", v1, O_RST);           tick();
        drive(0, 7'b0110011, 3'd0, 0); chk("fetch_rden1", v1, O_RD1);          tick();
        drive(0, 7'b0110011, 3'd0, 0); chk("exec_rtype", v1, O_PC | O_RW);     tick();
        drive(0, 7'b0000011, 3'd0, 0); chk("rtype_2cyc", v1, O_RD1);           tick();

        // Load with interrupt raised in EXEC: EXEC, WB, INTR, FETCH
        drive(0, 7'b0000011, 3'd2, 1); chk("load_exec", v1, O_RD2);            tick();
        drive(0, 7'b0000011, 3'd2, 1); chk("load_wb", v1, O_PC | O_RW);        tick();
        drive(0, 7'b0000011, 3'd2, 1); chk("intr_entry", v1, O_PC | O_INT);
        chk("noint_fetch", v0, O_RD1);                                          tick();
        drive(0, 7'b1110011, 3'd0, 1); chk("intr_to_fetch", v1, O_RD1);        tick();

        // MRET with interrupt pending goes straight back into the trap
        drive(0, 7'b1110011, 3'd0, 1); chk("mret_exec", v1, O_PC | O_MRET);    tick();
        drive(0, 7'b1110011, 3'd2, 0); chk("mret_to_intr", v1, O_PC | O_INT);  tick();
        drive(0, 7'b1110011, 3'd2, 0); tick();
        drive(0, 7'b1110011, 3'd2, 0); chk("csrrs", v1, O_PC | O_RW | O_CSR);  tick();
        drive(0, 7'b1110011, 3'd4, 0); tick();
        drive(0, 7'b1110011, 3'd4, 0); chk("sys_f3_4", v1, O_PC);              tick();
        drive(0, 7'b0100011, 3'd0, 0); tick();
        drive(0, 7'b0100011, 3'd0, 0); chk("store", v1, O_PC | O_WE);          tick();
        drive(0, 7'b1111111, 3'd0, 0); tick();
        drive(0, 7'b1111111, 3'd0, 0); chk("unknown_op", v1, O_PC);            tick();

        // Reset during the WB of a load
        drive(0, 7'b0000011, 3'd0, 0); tick();
        drive(0, 7'b0000011, 3'd0, 0); tick();
        drive(1, 7'b0000011, 3'd0, 0); chk("wb_before_rst", v1, O_PC | O_RW);  tick();
        drive(0, 7'b0000011, 3'd0, 0); chk("rst_in_wb", v1, O_RST);            tick();

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
            drive(($urandom_range(0, 40) == 0), op, 3'($urandom), ($urandom_range(0, 2) == 0));
            tick();
        end

        chk("intr_en0_never_trap", {31'd0, en0_trapped}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
